// File: rtl/scu_dispatcher.sv
// ---------------------------------------------------------------------------
// scu_dispatcher
//
// Accepts one activation vector and one weight vector per transaction. It
// then streams out only the lanes that have a nonzero weight, lowest lane
// first, one (activation, weight) pair per cycle toward the SCU. An all-zero
// weight vector is skipped entirely: the block spends a single FLUSH cycle
// and pulses done.
//
// Parameters
//   DATA_W  element width (signed two's complement)
//   LANES   elements per vector (power of two, 2..32)
//   IDX_W   lane index width, log2(LANES)
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    vector handshake; in_ready is high only in IDLE
//   in_act, in_weight      packed vectors, lane k at [k*DATA_W +: DATA_W]
//   out_valid / out_ready  pair handshake toward the SCU
//   act_out, weight_out    current nonzero-weight pair (0 when !out_valid)
//   out_idx, out_last      lane of the current pair, final pair of vector
//   nnz_count              nonzero weights in the last accepted vector
//   done                   one-cycle vector-complete pulse
// ---------------------------------------------------------------------------
module scu_dispatcher #(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int IDX_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_act,
    input  logic [LANES*DATA_W-1:0]   in_weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  act_out,
    output logic signed [DATA_W-1:0]  weight_out,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic [IDX_W:0]            nnz_count,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic [LANES*DATA_W-1:0] act_q, act_d;
    logic [LANES*DATA_W-1:0] weight_q, weight_d;
    logic [IDX_W:0]          nnz_q, nnz_d;
    logic                    done_q, done_d;

    // Nonzero mask and popcount of the vector currently being offered.
    logic [LANES-1:0] in_mask;
    logic [IDX_W:0]   in_pop;

    always_comb begin
        in_mask = '0;
        in_pop  = '0;
        for (int k = 0; k < LANES; k++) begin
            in_mask[k] = (in_weight[k*DATA_W +: DATA_W] != '0);
            in_pop     = in_pop + (IDX_W+1)'(in_mask[k]);
        end
    end

    // Lowest set mask bit and the registered lane values it selects.
    // Everything here depends only on flops, so the pair outputs carry no
    // combinational path from any input.
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_act;
    logic [DATA_W-1:0] sel_weight;
    logic              sel_found;
    logic              sel_last;

    always_comb begin
        sel_idx    = '0;
        sel_act    = '0;
        sel_weight = '0;
        sel_found  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (mask_q[k] && !sel_found) begin
                sel_idx    = IDX_W'(k);
                sel_act    = act_q[k*DATA_W +: DATA_W];
                sel_weight = weight_q[k*DATA_W +: DATA_W];
                sel_found  = 1'b1;
            end
        end
        // Exactly one bit left: clearing the lowest set bit leaves nothing.
        sel_last = (mask_q != '0) && ((mask_q & (mask_q - LANES'(1))) == '0);
    end

    // Output drive: pair fields are forced to zero whenever no pair is valid.
    // in_ready is gated by rst_n so it stays low for the whole reset period.
    always_comb begin
        out_valid  = (state_q == SCAN) && sel_found;
        act_out    = out_valid ? sel_act    : '0;
        weight_out = out_valid ? sel_weight : '0;
        out_idx    = out_valid ? sel_idx    : '0;
        out_last   = out_valid ? sel_last   : 1'b0;
        in_ready   = (state_q == IDLE) && rst_n;
        nnz_count  = nnz_q;
        done       = done_q;
    end

    // Next-state logic. done_d is raised on the edge that finishes a vector
    // so done appears in the following cycle: the cycle after the last pair
    // handshake, or the FLUSH cycle for an all-zero vector.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        act_d    = act_q;
        weight_d = weight_q;
        nnz_d    = nnz_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    act_d    = in_act;
                    weight_d = in_weight;
                    mask_d   = in_mask;
                    nnz_d    = in_pop;
                    if (in_mask != '0) begin
                        state_d = SCAN;
                    end else begin
                        state_d = FLUSH;
                        done_d  = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    mask_d[sel_idx] = 1'b0;
                    if (sel_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight vector without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            act_q    <= '0;
            weight_q <= '0;
            nnz_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            act_q    <= act_d;
            weight_q <= weight_d;
            nnz_q    <= nnz_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: doc/scu_dispatcher.md
SCU_DISPATCHER -- requirements
Module: scu_dispatcher

Interface
REQ-001 SHALL have parameter DATA_W, default 16: activation/weight element width, signed two's complement.
REQ-002 SHALL have parameter LANES, default 8: elements per input vector, power of two, 2..32.
REQ-003 SHALL have parameter IDX_W, default 3: lane index width, equal to log2(LANES).
REQ-004 SHALL have ports clk input 1 (clock, rising edge) and rst_n input 1; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 SHALL have in_valid input 1: upstream vector offer.
REQ-006 SHALL have in_ready output 1: dispatcher accepts a vector this cycle.
REQ-007 SHALL have in_act input LANES*DATA_W and in_weight input LANES*DATA_W: packed vectors, lane k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have out_valid output 1, out_ready input 1: pair handshake toward the SCU.
REQ-009 SHALL have act_out and weight_out outputs DATA_W (signed): the current nonzero-weight pair.
REQ-010 SHALL have out_idx output IDX_W (lane of the current pair) and out_last output 1 (final pair of the vector).
REQ-011 SHALL have nnz_count output IDX_W+1 (nonzero weights in the last accepted vector) and done output 1 (vector-complete pulse).

Function
REQ-012 SHALL implement states IDLE, SCAN, FLUSH; in_ready=1 only in IDLE.
REQ-013 SHALL accept a vector when in_valid && in_ready: register both vectors, set mask bit k iff weight lane k != 0 (full-width compare), register nnz_count = popcount(mask).
REQ-014 SHALL transition IDLE->SCAN on accept with mask nonzero, and IDLE->FLUSH on accept with mask all-zero.
REQ-015 SHALL in SCAN drive out_valid=1 with the lowest-index set mask bit: out_idx = that lane, act_out/weight_out = that lane's registered values.
REQ-016 SHALL assert out_last in SCAN iff exactly one mask bit remains.
REQ-017 SHALL on out_valid && out_ready clear the presented mask bit; if out_last, go to IDLE and pulse done=1 for the following cycle.
REQ-018 SHALL hold out_valid, act_out, weight_out, out_idx, out_last stable while out_valid && !out_ready (no mask change).
REQ-019 SHALL in FLUSH emit no pairs, pulse done=1 for exactly that cycle, and return to IDLE next edge.
REQ-020 SHALL drive act_out, weight_out, out_idx, out_last to 0 whenever out_valid=0.
REQ-021 SHALL have first out_valid the cycle after the accept edge; sustained throughput one pair per cycle with out_ready=1; a vector with N>0 nonzeros occupies exactly N SCAN cycles under no backpressure.
REQ-022 SHALL allow a new accept in the same cycle done=1 (in_ready=1 in IDLE); nnz_count holds until the next accept.
REQ-023 SHALL have no combinational path from in_valid, in_act, in_weight, or out_ready to any output.
REQ-024 SHALL ignore in_valid outside IDLE; offered data is not captured.

Reset
REQ-025 SHALL on rst_n=0 immediately force state IDLE, mask 0, registered vectors 0, nnz_count 0, done 0, out_valid 0, and in_ready low until reset deasserts (in_ready=1 in the first cycle after deassertion).
REQ-026 SHALL on reset mid-SCAN drop the in-flight vector with no further pairs and no done pulse.

Verification
REQ-027 SHALL cover: weights {0,5,0,-3,0,0,7,0}, acts {1..8}, out_ready=1 -> pairs (idx1,2,5),(idx3,4,-3),(idx6,7,7) on consecutive cycles, out_last on idx6, nnz_count=3, done one cycle after.
REQ-028 SHALL cover: all-zero weights -> no out_valid, nnz_count=0, done pulses exactly one cycle after accept, in_ready=1 the cycle after.
REQ-029 SHALL cover: all 8 weights nonzero, out_ready low 3 cycles on idx2 -> idx2 pair held unchanged 4 cycles, 8 pairs total in order 0..7, 11 SCAN cycles.
REQ-030 SHALL cover: weight only in lane 7 (0x8000) -> single pair idx7, weight_out=-32768, out_last=1 on that same cycle.
REQ-031 SHALL cover: rst_n low after second of 4 pairs -> out_valid=0 immediately, no done, nnz_count=0; next vector dispatches normally.
REQ-032 SHALL cover: in_valid held high with back-to-back vectors -> second accepted in the done cycle, its first pair the next cycle, no bubble beyond done.
